cordic_ip_arbiter: RTL and testbench
====================================

Name: cordic_ip_arbiter

Overview:
- Shares one iterative CORDIC core between two sample requesters (channel 0 and channel 1) in the ICA rotation datapath.
- Accepts DATA_WIDTH x/y pairs over valid/ready and grants the core round-robin.
- Upscales the granted pair to CORDIC_WIDTH by appending LSB zeros, pulses the core start, waits for done, and returns the result tagged with the channel id over valid/ready.

Parameters:
- DATA_WIDTH, 16, width of requester x/y samples.
- CORDIC_WIDTH, 22, internal CORDIC word width; must be >= DATA_WIDTH.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with CORDIC_IP_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- req0_valid  in  1  channel 0 sample pair valid.
- req0_ready  out  1  channel 0 accept.
- req0_x, req0_y  in  DATA_WIDTH each  channel 0 samples.
- req1_valid, req1_ready, req1_x, req1_y  as channel 0, for channel 1.
- cordic_start  out  1  one-cycle start pulse to core.
- cordic_x, cordic_y  out  CORDIC_WIDTH each  upscaled operands, held stable from start until done.
- cordic_done  in  1  core completion pulse.
- cordic_xr, cordic_yr  in  CORDIC_WIDTH each  core results, valid with cordic_done.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accept.
- res_id  out  1  channel id of result.
- res_x, res_y  out  CORDIC_WIDTH each  result words.
- res_err  out  1  timeout flag.

Behaviour:
- Reset values (rst_n sampled low at a clk edge): state IDLE; cordic_start, res_valid, res_err, res_id = 0; cordic_x/y, res_x/y = 0; last_grant = 1, so channel 0 wins first.
- Reset mid-operation: returns to IDLE at once. Any in-flight core result is discarded. A cordic_done arriving after reset is ignored.
- FSM states: IDLE -> ISSUE -> WAIT -> OUT -> IDLE.
- IDLE:
  - Combinational grant: if only one valid, grant it.
  - If both valid, grant the channel != last_grant.
  - reqN_ready = 1 only for the granted channel and only in IDLE; no ready in any other state.
  - On handshake: cordic_x <= {x, (CORDIC_WIDTH-DATA_WIDTH) zeros}, same for y; res_id <= grant; last_grant <= grant; go to ISSUE.
- ISSUE: cordic_start = 1 for exactly this cycle; go to WAIT.
- WAIT:
  - On cordic_done: capture cordic_xr/yr into res_x/y, res_err <= 0, go to OUT.
  - cordic_done in IDLE, ISSUE or OUT is ignored.
- OUT:
  - res_valid = 1; res_x/y/id/err held stable until res_ready.
  - On res_valid && res_ready, go to IDLE; res_valid falls next cycle.
- Latency:
  - Accept at cycle T; cordic_start at T+1.
  - If done arrives at cycle D (D >= T+2), res_valid is first high at D+1.
  - With res_ready held high, the next accept is possible at D+2.
- Throughput: one transaction in flight; no queuing.
- Fairness: under continuous requests on both channels, grants alternate 0,1,0,1.
- CORDIC_WIDTH == DATA_WIDTH is legal: zero-width pad, operands pass through unchanged.

Optional Feature:
- Macro: CORDIC_IP_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If the count reaches TIMEOUT_CYCLES without done: go to OUT with res_x = res_y = 0, res_err = 1, res_id = the granted channel.
  - Late done pulses after the timeout are ignored.
- Undefined: no counter; WAIT persists until done; res_err is tied 0.

Test Plan:
- Upscale: req0 x=16'h8001, y=16'h0003 -> cordic_x=22'h200040, cordic_y=22'h0000C0 at start. Core echoes operands after 5 cycles -> res_valid with res_id=0 and those values.
- Simultaneous: both channels valid from reset, 4 transactions each -> grant order 0,1,0,1,…; each res_id matches the issuing channel's data.
- Back-pressure: res_ready held 0 for 10 cycles in OUT -> res_* stable, both ready = 0, no cordic_start. Raise res_ready -> back to IDLE the next cycle.
- Reset mid-WAIT: rst_n low for 1 cycle after start, then done pulse -> no res_valid; all outputs 0; the next request proceeds normally with channel 0 priority.
- Spurious done in IDLE and a done 1 cycle after start (D=T+2) -> the IDLE pulse is ignored; the second is captured, res_valid at T+3.
- With CORDIC_IP_TIMEOUT_EN, TIMEOUT_CYCLES=8, no done -> res_valid 8 cycles into WAIT with res_err=1, res_x=res_y=0; without the macro, no result within 100 cycles.

Source files
------------

// File: rtl/cordic_ip_arbiter.sv
// cordic_ip_arbiter: round-robin share of one iterative CORDIC core between two
// sample requesters. Granted x/y pairs are upscaled to CORDIC_WIDTH with LSB
// zero padding, the core is started, and its result is returned with the
// channel id over a valid/ready result port.
// Optional feature macro: CORDIC_IP_TIMEOUT_EN (WAIT watchdog, sets res_err).
module cordic_ip_arbiter #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned CORDIC_WIDTH   = 22,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [DATA_WIDTH-1:0]   req0_x,
    input  logic [DATA_WIDTH-1:0]   req0_y,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [DATA_WIDTH-1:0]   req1_x,
    input  logic [DATA_WIDTH-1:0]   req1_y,
    output logic                    cordic_start,
    output logic [CORDIC_WIDTH-1:0] cordic_x,
    output logic [CORDIC_WIDTH-1:0] cordic_y,
    input  logic                    cordic_done,
    input  logic [CORDIC_WIDTH-1:0] cordic_xr,
    input  logic [CORDIC_WIDTH-1:0] cordic_yr,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_id,
    output logic [CORDIC_WIDTH-1:0] res_x,
    output logic [CORDIC_WIDTH-1:0] res_y,
    output logic                    res_err
);

    localparam int unsigned PAD_WIDTH = CORDIC_WIDTH - DATA_WIDTH;

    // Reject configurations the datapath cannot represent.
    if (CORDIC_WIDTH < DATA_WIDTH || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("cordic_ip_arbiter: CORDIC_WIDTH must be >= DATA_WIDTH and TIMEOUT_CYCLES > 0");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                state;
    logic                  last_grant;
    logic                  grant;
    logic                  any_valid;
    logic [DATA_WIDTH-1:0] sel_x;
    logic [DATA_WIDTH-1:0] sel_y;

`ifdef CORDIC_IP_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_WIDTH-1:0] wait_cnt;
`endif

    // Round-robin grant and ready: a lone requester wins, a tie goes to the
    // channel that did not win last time; ready only while idle.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        sel_x      = grant ? req1_x : req0_x;
        sel_y      = grant ? req1_y : req0_y;
        req0_ready = (state == IDLE) && req0_valid && !grant;
        req1_ready = (state == IDLE) && req1_valid && grant;
    end

    // Transaction FSM with registered core and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            cordic_start <= 1'b0;
            cordic_x     <= '0;
            cordic_y     <= '0;
            res_valid    <= 1'b0;
            res_id       <= 1'b0;
            res_x        <= '0;
            res_y        <= '0;
            res_err      <= 1'b0;
`ifdef CORDIC_IP_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            cordic_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        cordic_x     <= CORDIC_WIDTH'(sel_x) << PAD_WIDTH;
                        cordic_y     <= CORDIC_WIDTH'(sel_y) << PAD_WIDTH;
                        res_id       <= grant;
                        last_grant   <= grant;
                        cordic_start <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef CORDIC_IP_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (cordic_done) begin
                        res_x     <= cordic_xr;
                        res_y     <= cordic_yr;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= OUT;
`ifdef CORDIC_IP_TIMEOUT_EN
                    end else if (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        res_x     <= '0;
                        res_y     <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
`endif
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_ip_arbiter.sv
// Bench for cordic_ip_arbiter: directed sequence with random data, a simple
// behavioural core responder and a spec-level grant/result model.
module tb_cordic_ip_arbiter;

    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 22;
    localparam int unsigned TO    = 8;
    localparam int          SCALE = 1 << (CW - DW);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_x, req0_y, req1_x, req1_y;
    logic          cordic_start, cordic_done;
    logic [CW-1:0] cordic_x, cordic_y, cordic_xr, cordic_yr;
    logic          res_valid, res_ready, res_id, res_err;
    logic [CW-1:0] res_x, res_y;

    logic          core_done, spur_done, core_en;
    int            core_lat;
    logic [CW-1:0] key_x, key_y;
    logic          last_model;
    int            checks, passed, fails;

    assign cordic_done = core_done | spur_done;

    always #5 clk = ~clk;

    cordic_ip_arbiter #(
        .DATA_WIDTH(DW), .CORDIC_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .cordic_start(cordic_start), .cordic_x(cordic_x), .cordic_y(cordic_y),
        .cordic_done(cordic_done), .cordic_xr(cordic_xr), .cordic_yr(cordic_yr),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_x(res_x), .res_y(res_y), .res_err(res_err)
    );

    // Behavioural core: seen start, answer core_lat cycles later with operands ^ key.
    initial begin
        core_done = 1'b0;
        cordic_xr = '0;
        cordic_yr = '0;
        forever begin
            @(negedge clk);
            if (cordic_start === 1'b1 && core_en) begin
                logic [CW-1:0] ox, oy;
                ox = cordic_x;
                oy = cordic_y;
                repeat (core_lat) @(negedge clk);
                cordic_xr = ox ^ key_x;
                cordic_yr = oy ^ key_y;
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    function automatic logic [CW-1:0] up(input logic [DW-1:0] v);
        return CW'(int'(v) * SCALE);
    endfunction

    function automatic logic exp_grant(input logic v0, input logic v1);
        if (v0 && v1) return ~last_model;
        return v1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_res(input int max, output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Full transaction from an idle negedge with the request(s) already driven.
    task automatic run_txn(input logic g, input logic [DW-1:0] x, input logic [DW-1:0] y,
                           input int lat, input logic keep, input string tag);
        int n;
        logic [CW-1:0] ex, ey;
        core_lat = lat;
        #1;
        chk({tag, "_rdy0"}, req0_ready, !g);
        chk({tag, "_rdy1"}, req1_ready, g);
        @(negedge clk);
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        last_model = g;
        ex = up(x);
        ey = up(y);
        chk({tag, "_start"}, cordic_start, 1'b1);
        chk({tag, "_cx"}, cordic_x, ex);
        chk({tag, "_cy"}, cordic_y, ey);
        chk({tag, "_busy_rdy"}, req0_ready | req1_ready, 1'b0);
        wait_res(lat + 20, n);
        chk({tag, "_lat"}, n, lat + 1);
        chk({tag, "_id"}, res_id, g);
        chk({tag, "_rx"}, res_x, ex ^ key_x);
        chk({tag, "_ry"}, res_y, ey ^ key_y);
        chk({tag, "_err"}, res_err, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] d0 [4];
        logic [DW-1:0] e0 [4];
        logic [DW-1:0] d1 [4];
        logic [DW-1:0] e1 [4];
        int i0, i1, n;
        logic g, stable, seen;
        logic [CW-1:0] hx, hy;
        logic hid;

        checks = 0; passed = 0; fails = 0;
        rst_n = 1'b0; res_ready = 1'b0; core_en = 1'b1; core_lat = 1;
        spur_done = 1'b0; key_x = '0; key_y = '0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
        last_model = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_start", cordic_start, 1'b0);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_err", res_err, 1'b0);
        chk("rst_id", res_id, 1'b0);
        chk("rst_cx", {cordic_x, cordic_y}, '0);
        chk("rst_res", {res_x, res_y}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Upscale with an echoing core, 5-cycle latency
        req0_valid = 1'b1; req0_x = 16'h8001; req0_y = 16'h0003;
        run_txn(1'b0, 16'h8001, 16'h0003, 5, 1'b0, "up");
        chk("up_lit_x", res_x, 22'h200040);
        chk("up_lit_y", res_y, 22'h0000C0);
        res_ready = 1'b1;
        @(negedge clk);
        chk("up_fall", res_valid, 1'b0);

        // Simultaneous requests from reset: grants alternate
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_model = 1'b1;
        key_x = CW'($urandom); key_y = CW'($urandom);
        for (int k = 0; k < 4; k++) begin
            d0[k] = DW'($urandom); e0[k] = DW'($urandom);
            d1[k] = DW'($urandom); e1[k] = DW'($urandom);
        end
        i0 = 0; i1 = 0;
        for (int t = 0; t < 8; t++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_x = d0[i0 % 4]; req0_y = e0[i0 % 4];
            req1_x = d1[i1 % 4]; req1_y = e1[i1 % 4];
            g = exp_grant(1'b1, 1'b1);
            if (g) begin
                run_txn(g, d1[i1 % 4], e1[i1 % 4], int'($urandom_range(1, 6)), 1'b1, "rr");
                i1++;
            end else begin
                run_txn(g, d0[i0 % 4], e0[i0 % 4], int'($urandom_range(1, 6)), 1'b1, "rr");
                i0++;
            end
            @(negedge clk);
            chk("rr_fall", res_valid, 1'b0);
        end
        chk("rr_count0", i0, 4);
        chk("rr_count1", i1, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Back-pressure on the result port
        res_ready = 1'b0;
        req1_valid = 1'b1; req1_x = DW'($urandom); req1_y = DW'($urandom);
        run_txn(exp_grant(1'b0, 1'b1), req1_x, req1_y, 3, 1'b0, "bp");
        hx = up(req1_x) ^ key_x; hy = up(req1_y) ^ key_y; hid = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_x !== hx || res_y !== hy || res_id !== hid ||
                res_err !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
                cordic_start !== 1'b0)
                stable = 1'b0;
        end
        chk("bp_stable", stable, 1'b1);
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_fall", res_valid, 1'b0);
        chk("bp_idle_rdy0", req0_ready, 1'b1);
        chk("bp_idle_rdy1", req1_ready, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset during WAIT, core answers afterwards
        core_lat = 4;
        req0_valid = 1'b1; req0_x = DW'($urandom); req0_y = DW'($urandom);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("rw_start", cordic_start, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_model = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        chk("rw_no_res", seen, 1'b0);
        chk("rw_cx", {cordic_x, cordic_y}, '0);
        chk("rw_res", {res_x, res_y, res_id, res_err, cordic_start}, '0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_x = DW'($urandom); req0_y = DW'($urandom);
        req1_x = DW'($urandom); req1_y = DW'($urandom);
        run_txn(exp_grant(1'b1, 1'b1), req0_x, req0_y, 2, 1'b0, "rw_next");
        @(negedge clk);

        // Spurious done while idle, then the shortest legal core latency
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("sp_valid", res_valid, 1'b0);
        chk("sp_start", cordic_start, 1'b0);
        @(negedge clk);
        chk("sp_valid2", res_valid, 1'b0);
        req1_valid = 1'b1; req1_x = DW'($urandom); req1_y = DW'($urandom);
        run_txn(exp_grant(1'b0, 1'b1), req1_x, req1_y, 1, 1'b0, "sp");
        @(negedge clk);

        // Core never answers
        core_en = 1'b0;
        req0_valid = 1'b1; req0_x = DW'($urandom); req0_y = DW'($urandom);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("to_start", cordic_start, 1'b1);
        wait_res(100, n);
`ifdef CORDIC_IP_TIMEOUT_EN
        chk("to_lat", n, TO + 1);
        chk("to_err", res_err, 1'b1);
        chk("to_res", {res_x, res_y}, '0);
        chk("to_id", res_id, 1'b0);
`else
        chk("to_none", res_valid, 1'b0);
        chk("to_cycles", n, 100);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed hang, required finish");
        $fatal(1);
    end

endmodule
